// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle RV32I control FSM with memory wait timeout and trap
// Optional retire counter port Instr_Retired is enabled by defining CTRL_RETIRE_CNT_EN.
module multi_cycle_controller #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Rst_N,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             Mem_Ready,
    output logic             Mem_Req,
    output logic             Mem_Write,
    output logic             Adr_Src,
    output logic             Ir_Write,
    output logic             Pc_Write,
    output logic             Reg_Write,
    output logic [1:0]       Alu_Src_A,
    output logic [1:0]       Alu_Src_B,
    output logic [1:0]       Alu_Op,
    output logic [1:0]       Result_Src,
    output logic [1:0]       Imm_Src,
    output logic             Illegal,
    output logic             Bus_Err
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] Instr_Retired
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int              WAIT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam bit              TIMEOUT_EN = (WAIT_LIMIT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WAIT_W'(WAIT_LIMIT - 1) : '0;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic mem_req, mem_write, adr_src, ir_write, reg_write;
    logic pc_update, branch;
    logic wait_state;
    logic [1:0] alu_a, alu_b, alu_op, result_src;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        wait_state = 1'b0;
        alu_a      = 2'b00;
        alu_b      = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_b      = 2'b10;
                result_src = 2'b10;
                wait_state = 1'b1;
                if (Mem_Ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Old_PC + Imm: branch target is ready before BRANCH compares
                alu_a = 2'b01;
                alu_b = 2'b01;
                case (Opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_IALU:           state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_a   = 2'b10;
                alu_b   = 2'b01;
                state_d = (Opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                wait_state = 1'b1;
                if (Mem_Ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                wait_state = 1'b1;
                if (Mem_Ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alu_a   = 2'b10;
                alu_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_a   = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Ready on the last allowed cycle wins over the timeout
        if (wait_state && !Mem_Ready) begin
            if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
                state_d   = S_TRAP;
                bus_err_d = 1'b1;
                wait_d    = '0;
            end else if (TIMEOUT_EN) begin
                wait_d = wait_q + 1'b1;
            end
        end else begin
            wait_d = '0;
        end
    end

    always_comb begin
        case (Opcode)
            OP_STORE:  Imm_Src = 2'b01;
            OP_BRANCH: Imm_Src = 2'b10;
            default:   Imm_Src = 2'b00;
        endcase
    end

    // Strobes are gated by Rst_N so an abandoned access drops without waiting for a clock
    assign Mem_Req    = mem_req & Rst_N;
    assign Mem_Write  = mem_write & Rst_N;
    assign Ir_Write   = ir_write & Rst_N;
    assign Reg_Write  = reg_write & Rst_N;
    assign Pc_Write   = (pc_update | (branch & Zero)) & Rst_N;
    assign Adr_Src    = adr_src;
    assign Alu_Src_A  = alu_a;
    assign Alu_Src_B  = alu_b;
    assign Alu_Op     = alu_op;
    assign Result_Src = result_src;
    assign Illegal    = illegal_q;
    assign Bus_Err    = bus_err_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BRANCH));

    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign Instr_Retired = retired_q;
`endif

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Control FSM for the multi-cycle variant of the RV32I datapath.
- Sequences the shared ALU, the single unified memory port, the instruction register, the PC and the register file over 3–5 cycles per instruction.
- Supports load (0000011), I-ALU (0010011), store (0100011), R-type (0110011) and branch (1100011).
- Adds a memory ready handshake with timeout, and illegal-opcode trapping.

Parameters:
- WAIT_LIMIT, 0: maximum cycles to wait for Mem_Ready per access. 0 disables the timeout.
- CNT_W, 32: width of the optional retire counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_N  input  1  reset, asynchronous assert, active-low.
- Opcode  input  7  instruction register bits [6:0]; valid from DECODE onward.
- Zero  input  1  ALU zero flag.
- Mem_Ready  input  1  memory completes the current access this cycle.
- Mem_Req  output  1  memory access request.
- Mem_Write  output  1  store strobe; qualified by Mem_Req.
- Adr_Src  output  1  memory address select: 0 = PC, 1 = ALU_Out.
- Ir_Write  output  1  load the instruction register and Old_PC.
- Pc_Write  output  1  PC load enable.
- Reg_Write  output  1  register file write enable.
- Alu_Src_A  output  2  ALU A select: 00 = PC, 01 = Old_PC, 10 = rs1.
- Alu_Src_B  output  2  ALU B select: 00 = rs2, 01 = Imm, 10 = const 4.
- Alu_Op  output  2  00 = add, 01 = sub/compare, 10 = decode by funct fields.
- Result_Src  output  2  result select: 00 = ALU_Out, 01 = Mem_Data, 10 = ALU result.
- Imm_Src  output  2  immediate format: 00 = I, 01 = S, 10 = B.
- Illegal  output  1  sticky trap flag.
- Bus_Err  output  1  sticky timeout flag.
- Instr_Retired  output  CNT_W  retire count; present only with the macro defined.

Behaviour:
- State register: one-hot or binary (implementer's choice).
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, TRAP.
- Reset (Rst_N low, asynchronous):
  - State = FETCH. Illegal = 0, Bus_Err = 0, wait counter = 0.
  - While Rst_N is low, Mem_Req, Mem_Write, Ir_Write, Pc_Write and Reg_Write are forced to 0.
- Output rules:
  - Outputs are Moore, decoded from state. Any output not listed for a state is 0.
  - Pc_Write = Pc_Update | (Branch_i & Zero), where Pc_Update and Branch_i are internal state decodes.
  - Imm_Src is combinational from Opcode in every state: S = 01, B = 10, everything else = 00.
- FETCH:
  - Mem_Req = 1, Adr_Src = 0, A = 00, B = 10, Alu_Op = 00, Result_Src = 10.
  - Ir_Write and Pc_Update are asserted only in the cycle where Mem_Ready = 1; then go to DECODE. Otherwise hold.
- DECODE:
  - A = 01, B = 01, Alu_Op = 00 (precomputes the branch target).
  - Next state by Opcode: load/store -> MEMADR; R -> EXECR; I -> EXECI; branch -> BRANCH; other -> TRAP.
- MEMADR:
  - A = 10, B = 01, Alu_Op = 00.
  - Next: load -> MEMREAD, store -> MEMWRITE.
- MEMREAD:
  - Mem_Req = 1, Adr_Src = 1, Result_Src = 00.
  - Hold until Mem_Ready, then -> MEMWB.
- MEMWB: Reg_Write = 1, Result_Src = 01; -> FETCH.
- MEMWRITE:
  - Mem_Req = 1, Mem_Write = 1, Adr_Src = 1, Result_Src = 00.
  - Hold until Mem_Ready, then -> FETCH.
- EXECR: A = 10, B = 00, Alu_Op = 10; -> ALUWB.
- EXECI: A = 10, B = 01, Alu_Op = 10; -> ALUWB.
- ALUWB: Reg_Write = 1, Result_Src = 00; -> FETCH.
- BRANCH:
  - A = 10, B = 00, Alu_Op = 01, Result_Src = 00, Branch_i = 1.
  - PC loads the target only if Zero = 1. -> FETCH.
- TRAP:
  - Entered from DECODE: Illegal = 1. Entered via timeout: Bus_Err = 1.
  - All write enables and Mem_Req are 0. The state is left only by reset.
- Timeout (WAIT_LIMIT > 0):
  - The counter increments in each cycle a wait state (FETCH, MEMREAD, MEMWRITE) has Mem_Ready = 0.
  - The counter clears whenever the state advances.
  - When the counter reaches WAIT_LIMIT with Mem_Ready still 0 -> TRAP, Bus_Err = 1.
  - Mem_Ready = 1 in the same cycle the counter reaches WAIT_LIMIT counts as success; no trap.
- Cycle counts with Mem_Ready tied high:
  - load 5; store 4; R/I 4; branch 3.
- Mem_Ready asserted while Mem_Req = 0 is ignored.
- Reset mid-instruction: the access is abandoned and outputs drop immediately. Fetch restarts after the Rst_N release edge.

Optional Feature:
- Macro: CTRL_RETIRE_CNT_EN.
- Defined:
  - Instr_Retired (CNT_W bits) resets to 0.
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Wraps modulo 2^CNT_W; does not count in TRAP.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- R-type 0110011, Mem_Ready = 1 -> states FETCH, DECODE, EXECR, ALUWB. Reg_Write = 1 only in cycle 4 with Result_Src = 00. Back in FETCH in cycle 5.
- Load 0000011, Mem_Ready low for 3 cycles in MEMREAD -> Mem_Req, Adr_Src = 1 held for 4 cycles. MEMWB asserts Reg_Write = 1 with Result_Src = 01. Total 8 cycles.
- Branch 1100011 with Zero = 1 -> Pc_Write = 1 in the BRANCH cycle. Repeat with Zero = 0 -> Pc_Write = 0. Both return to FETCH.
- Opcode 1111111 -> TRAP after DECODE, Illegal = 1. Write enables stay 0 for 10 cycles. Rst_N low clears Illegal and returns to FETCH.
- WAIT_LIMIT = 4, Mem_Ready held 0 in FETCH -> Bus_Err = 1 after 4 wait cycles, TRAP. Second run with Mem_Ready = 1 on cycle 4 -> no trap, DECODE entered.
- CTRL_RETIRE_CNT_EN, CNT_W = 4, 17 R-type instructions -> Instr_Retired = 1 (wrap).
